// File: rtl/alu_hs.sv
// ---------------------------------------------------------------------------
// alu_hs -- handshaked, parametrised ALU with an iterative shift-add multiplier
//
// Operands and opcode are accepted on a valid/ready handshake. Single-cycle
// operations write the result register on the accepting edge. MUL runs a
// WIDTH-iteration shift-add loop, which stalls the input side while it runs.
// The result and status flags are held in registers until the consumer
// takes them with out_ready.
//
// Parameters:
//   WIDTH  operand/result width (>= 4, power of two)
//   SHW    shift-amount width, taken from b[SHW-1:0]
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands/opcode valid
//   in_ready   block accepts an operation this cycle
//   op         4-bit opcode
//   a, b       operands
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer accepts the result
//   result     registered result
//   zero       result == 0
//   carry      ADD carry-out / SUB borrow, 0 otherwise
//   overflow   signed overflow for ADD/SUB, 0 otherwise
//   negative   result MSB
//   illegal    opcode of the held result was undefined
//   busy       multiplier iterating
// ---------------------------------------------------------------------------
module alu_hs #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             illegal,
  output logic             busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_reg,     state_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] result_reg,    result_next;
  logic             zero_reg,      zero_next;
  logic             carry_reg,     carry_next;
  logic             overflow_reg,  overflow_next;
  logic             negative_reg,  negative_next;
  logic             illegal_reg,   illegal_next;
  logic [WIDTH-1:0] mcand_reg,     mcand_next;
  logic [WIDTH-1:0] mplier_reg,    mplier_next;
  logic [WIDTH-1:0] acc_reg,       acc_next;
  logic [CW-1:0]    cnt_reg,       cnt_next;

  // -------------------------------------------------------------------------
  // Single-cycle datapath
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] and_bits, or_bits, xor_bits, nor_bits;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, alu_ill;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_bits[gi] = a[gi] & b[gi];
      assign or_bits[gi]  = a[gi] | b[gi];
      assign xor_bits[gi] = a[gi] ^ b[gi];
      assign nor_bits[gi] = ~(a[gi] | b[gi]);
    end
  endgenerate

  // One extra bit on each side captures ADD carry-out and SUB borrow; the
  // borrow bit doubles as the unsigned less-than result.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (op)
      OP_AND:  alu_res = and_bits;
      OP_OR:   alu_res = or_bits;
      OP_XOR:  alu_res = xor_bits;
      OP_NOR:  alu_res = nor_bits;
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        // Same-sign operands producing a different-sign sum.
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        // Opposite-sign operands where the difference takes b's sign.
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_MUL:  alu_res = '0;  // handled by the iterative multiplier
      default: alu_ill = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Multiplier step: conditional add of the shifted multiplicand
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] acc_step;
  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic accept;
  assign in_ready = (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    // A consumed result drops out_valid unless a new one loads this edge.
    out_valid_next = out_ready ? 1'b0 : out_valid_reg;
    result_next    = result_reg;
    zero_next      = zero_reg;
    carry_next     = carry_reg;
    overflow_next  = overflow_reg;
    negative_next  = negative_reg;
    illegal_next   = illegal_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_next  = a;
            mplier_next = b;
            acc_next    = '0;
            cnt_next    = '0;
            state_next  = S_MUL;
          end else begin
            result_next    = alu_res;
            zero_next      = (alu_res == '0);
            carry_next     = alu_carry;
            overflow_next  = alu_ovf;
            negative_next  = alu_res[WIDTH-1];
            illegal_next   = alu_ill;
            out_valid_next = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        // Final iteration: publish the product on the same edge.
        if (cnt_reg == CNT_LAST) begin
          result_next    = acc_step;
          zero_next      = (acc_step == '0);
          carry_next     = 1'b0;
          overflow_next  = 1'b0;
          negative_next  = acc_step[WIDTH-1];
          illegal_next   = 1'b0;
          out_valid_next = 1'b1;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b1;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      negative_reg  <= 1'b0;
      illegal_reg   <= 1'b0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
      zero_reg      <= zero_next;
      carry_reg     <= carry_next;
      overflow_reg  <= overflow_next;
      negative_reg  <= negative_next;
      illegal_reg   <= illegal_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign overflow  = overflow_reg;
  assign negative  = negative_reg;
  assign illegal   = illegal_reg;
  assign busy      = (state_reg == S_MUL);

endmodule

// File: tb/tb_alu_hs.sv
// ---------------------------------------------------------------------------
// tb_alu_hs -- directed self-checking bench for alu_hs (WIDTH=16)
// ---------------------------------------------------------------------------
module tb_alu_hs;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        negative;
  logic        illegal;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_hs #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    $display("issue op=%b a=%h b=%h in_ready=%b", o, x, y, in_ready);
  endtask

  task automatic test_reset();
    // Hold a result with backpressure, then reset mid-cycle.
    out_ready = 1'b0;
    present(4'b0011, 16'h1234, 16'h00FF);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    $display("reset asserted: result=%h out_valid=%b zero=%b", result, out_valid, zero);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rst_result got=%h exp=0000", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rst_zero got=%b exp=1", zero); end
    checks++; if ({carry, overflow, negative, illegal, busy} !== 5'b00000) begin
      errors++; $display("FAIL rst_flags got=%b exp=00000", {carry, overflow, negative, illegal, busy});
    end
    @(negedge clock);
    reset_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    present(4'b0010, 16'h7FFF, 16'h0001);          // ADD
    step();
    $display("add result=%h c=%b v=%b n=%b", result, carry, overflow, negative);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 16'h8000) begin errors++; $display("FAIL add_result got=%h exp=8000", result); end
    checks++; if ({carry, overflow, negative} !== 3'b011) begin
      errors++; $display("FAIL add_flags got=%b exp=011", {carry, overflow, negative});
    end
    present(4'b0110, 16'h0003, 16'h0005);          // SUB
    step();
    $display("sub result=%h c=%b v=%b n=%b", result, carry, overflow, negative);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 16'hFFFE) begin errors++; $display("FAIL sub_result got=%h exp=fffe", result); end
    checks++; if ({carry, overflow, negative} !== 3'b101) begin
      errors++; $display("FAIL sub_flags got=%b exp=101", {carry, overflow, negative});
    end
    present(4'b0000, 16'h0F0F, 16'h00FF);          // AND
    step();
    in_valid = 1'b0;
    $display("and result=%h c=%b", result, carry);
    checks++; if (result !== 16'h000F) begin errors++; $display("FAIL and_result got=%h exp=000f", result); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL and_carry got=%b exp=0", carry); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_compare_shift();
    out_ready = 1'b1;
    present(4'b0111, 16'hFFFF, 16'h0001);          // SLT
    step();
    $display("slt result=%h", result);
    checks++; if (result !== 16'h0001) begin errors++; $display("FAIL slt got=%h exp=0001", result); end
    present(4'b1001, 16'hFFFF, 16'h0001);          // SLTU
    step();
    $display("sltu result=%h zero=%b", result, zero);
    checks++; if (result !== 16'h0000 || zero !== 1'b1) begin
      errors++; $display("FAIL sltu got=%h z=%b exp=0000 z=1", result, zero);
    end
    present(4'b1000, 16'h8000, 16'h0013);          // SRA by 3
    step();
    $display("sra result=%h", result);
    checks++; if (result !== 16'hF000) begin errors++; $display("FAIL sra got=%h exp=f000", result); end
    present(4'b0100, 16'h0001, 16'h000F);          // SLL by 15
    step();
    $display("sll result=%h", result);
    checks++; if (result !== 16'h8000) begin errors++; $display("FAIL sll got=%h exp=8000", result); end
    present(4'b0101, 16'h8000, 16'h0004);          // SRL by 4
    step();
    $display("srl result=%h", result);
    checks++; if (result !== 16'h0800) begin errors++; $display("FAIL srl got=%h exp=0800", result); end
    present(4'b1011, 16'h0F0F, 16'h00FF);          // NOR
    step();
    in_valid = 1'b0;
    $display("nor result=%h", result);
    checks++; if (result !== 16'hF000) begin errors++; $display("FAIL nor got=%h exp=f000", result); end
    step();
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    // 0x0123 * 0x0045 = 291 * 69 = 20079 = 0x4E6F
    present(4'b1010, 16'h0123, 16'h0045);
    step();
    // Operands change right after acceptance; product must not follow.
    in_valid = 1'b0;
    a = 16'hAAAA;
    b = 16'h5555;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mul_busy_start busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready);
    end
    for (int k = 1; k < 16; k++) begin
      step();
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL mul_iter%0d busy=%b out_valid=%b exp busy=1 out_valid=0", k, busy, out_valid);
      end
    end
    step();
    $display("mul result=%h out_valid=%b busy=%b", result, out_valid, busy);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 16'h4E6F) begin errors++; $display("FAIL mul_result got=%h exp=4e6f", result); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mul_done busy=%b in_ready=%b exp busy=0 in_ready=1", busy, in_ready);
    end
    present(4'b1010, 16'hFFFF, 16'hFFFF);
    step();
    in_valid = 1'b0;
    repeat (16) step();
    $display("mul result=%h out_valid=%b", result, out_valid);
    checks++; if (out_valid !== 1'b1 || result !== 16'h0001) begin
      errors++; $display("FAIL mul_ffff got=%h v=%b exp=0001 v=1", result, out_valid);
    end
    checks++; if ({zero, carry, overflow, negative} !== 4'b0000) begin
      errors++; $display("FAIL mul_ffff_flags got=%b exp=0000", {zero, carry, overflow, negative});
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    present(4'b0011, 16'h1234, 16'h00FF);          // XOR -> 12CB
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 16'h12CB) begin
      errors++; $display("FAIL bp_first got=%h v=%b exp=12cb v=1", result, out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (result !== 16'h12CB || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d result=%h v=%b in_ready=%b exp 12cb 1 0", k, result, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    present(4'b0001, 16'h0F00, 16'h00F0);          // OR -> 0FF0
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    $display("or result=%h out_valid=%b", result, out_valid);
    checks++; if (out_valid !== 1'b1 || result !== 16'h0FF0) begin
      errors++; $display("FAIL bp_next got=%h v=%b exp=0ff0 v=1", result, out_valid);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    present(4'b1111, 16'h0005, 16'h0003);
    step();
    in_valid = 1'b0;
    $display("illegal result=%h zero=%b illegal=%b", result, zero, illegal);
    checks++; if (result !== 16'h0000 || zero !== 1'b1 || illegal !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL illegal got=%h z=%b i=%b v=%b exp 0000 1 1 1", result, zero, illegal, out_valid);
    end
    step();
  endtask

  task automatic test_mul_abort();
    logic saw_valid;
    out_ready = 1'b1;
    present(4'b1010, 16'h0123, 16'h0045);
    step();
    in_valid = 1'b0;
    repeat (6) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got=%b exp=1", busy); end
    #2;
    reset_n = 1'b0;
    #1;
    $display("reset during mul: busy=%b out_valid=%b", busy, out_valid);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_reset busy=%b v=%b exp 0 0", busy, out_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result saw=%b exp=0", saw_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    op        = 4'b0000;
    a         = 16'h0000;
    b         = 16'h0000;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0 || result !== 16'h0000 || zero !== 1'b1) begin
      errors++; $display("FAIL init_reset v=%b r=%h z=%b exp 0 0000 1", out_valid, result, zero);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step();
    test_back_to_back();
    test_compare_shift();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset();
    test_mul_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
